// File: rtl/chcoder_pkg.sv
// Shared channel-coder definitions: code-block sizes, CRC-24B polynomial,
// the attach-stage state encoding and the serial CRC step helper.
package chcoder_pkg;

    localparam int          SMALL_K     = 1056;
    localparam int          LARGE_K     = 6144;
    localparam int          CRC_W       = 24;
    localparam int          CNT_W       = 13;
    localparam logic [23:0] CRC24B_POLY = 24'h800063;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_ALIGN     = 3'd2,
        ST_DATA      = 3'd3,
        ST_CRC       = 3'd4,
        ST_WAIT_DONE = 3'd5
    } cb_state_e;

    // One bit-serial step of an MSB-first CRC-24 register
    function automatic logic [23:0] crc24_step(input logic [23:0] crc,
                                               input logic        din,
                                               input logic [23:0] poly);
        logic fb;
        fb = crc[23] ^ din;
        return {crc[22:0], 1'b0} ^ (fb ? poly : 24'd0);
    endfunction

endpackage

// File: rtl/crc24_cb_attach_if.sv
// Bit-stream source and interleaver-control bundle seen by the CRC attach stage.
interface crc24_cb_attach_if;

    logic       tb_start;
    logic       tb_blk_size;
    logic [3:0] tb_num_blocks;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic       il_done;
    logic       out_bit;
    logic       out_valid;
    logic       crc_start;
    logic       crc_end;
    logic       block_size;
    logic       busy;
    logic       err;

    modport master (
        output tb_start, tb_blk_size, tb_num_blocks, in_bit, in_valid, il_done,
        input  in_ready, out_bit, out_valid, crc_start, crc_end, block_size, busy, err
    );

    modport slave (
        input  tb_start, tb_blk_size, tb_num_blocks, in_bit, in_valid, il_done,
        output in_ready, out_bit, out_valid, crc_start, crc_end, block_size, busy, err
    );

endinterface

// File: rtl/crc24_serial.sv
// Bit-serial CRC-24 LFSR with clear, update and shift-out controls.
module crc24_serial
    import chcoder_pkg::*;
#(
    parameter logic [23:0] POLY = CRC24B_POLY
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        shift,
    input  logic        din,
    output logic [23:0] crc
);

    logic [23:0] crc_r;

    // Clear has priority so a block boundary can restart the register mid shift-out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_r <= 24'd0;
        end else if (clr) begin
            crc_r <= 24'd0;
        end else if (en) begin
            crc_r <= crc24_step(crc_r, din, POLY);
        end else if (shift) begin
            crc_r <= {crc_r[22:0], 1'b0};
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/crc24_cb_attach.sv
// Splits a serial transport block into code blocks, appends CRC-24B to each,
// and sequences the interleaver CRC_start / CRC_END / block_size controls.
module crc24_cb_attach
    import chcoder_pkg::*;
#(
    parameter int          SMALL_K_P  = SMALL_K,
    parameter int          LARGE_K_P  = LARGE_K,
    parameter int          CRC_W_P    = CRC_W,
    parameter logic [23:0] CRC_POLY   = CRC24B_POLY,
    parameter int          CNT_W_P    = CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    crc24_cb_attach_if.slave     bus
);

    localparam logic [CNT_W_P-1:0] SMALL_LAST = CNT_W_P'(SMALL_K_P - CRC_W_P - 1);
    localparam logic [CNT_W_P-1:0] LARGE_LAST = CNT_W_P'(LARGE_K_P - CRC_W_P - 1);
    localparam logic [CNT_W_P-1:0] CRC_LAST   = CNT_W_P'(CRC_W_P - 1);

    cb_state_e          state_r;
    logic [CNT_W_P-1:0] cnt_r;
    logic [3:0]         blk_left_r;
    logic               crc_start_r;
    logic               crc_end_r;
    logic               block_size_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               err_r;

    logic [CNT_W_P-1:0] data_last_s;
    logic               out_bit_s;
    logic               crc_clr_s;
    logic               crc_en_s;
    logic               crc_shift_s;
    logic [23:0]        crc_s;

    // Last payload-count value for the latched block size
    always_comb begin
        data_last_s = SMALL_LAST;
        if (block_size_r) begin
            data_last_s = LARGE_LAST;
        end else begin
            data_last_s = SMALL_LAST;
        end
    end

    // Output bit and CRC controls; the payload path is combinational because
    // the interleaver expects the bit in the same cycle the stage consumes it
    always_comb begin
        out_bit_s   = 1'b0;
        crc_clr_s   = 1'b0;
        crc_en_s    = 1'b0;
        crc_shift_s = 1'b0;
        case (state_r)
            ST_ALIGN: begin
                crc_clr_s = 1'b1;
            end
            ST_DATA: begin
                out_bit_s = bus.in_valid & bus.in_bit;
                crc_en_s  = 1'b1;
            end
            ST_CRC: begin
                out_bit_s   = crc_s[23];
                crc_shift_s = 1'b1;
                crc_clr_s   = (cnt_r == CRC_LAST) && (blk_left_r > 4'd1);
            end
            default: begin
                out_bit_s = 1'b0;
            end
        endcase
    end

    crc24_serial #(
        .POLY (CRC_POLY)
    ) u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (crc_clr_s),
        .en      (crc_en_s),
        .shift   (crc_shift_s),
        .din     (out_bit_s),
        .crc     (crc_s)
    );

    // Block sequencer; control outputs are registered on the transition into each state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            blk_left_r   <= 4'd0;
            crc_start_r  <= 1'b0;
            crc_end_r    <= 1'b0;
            block_size_r <= 1'b0;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.tb_start) begin
                        // small blocks have no multi-block interleaver mode
                        blk_left_r   <= (!bus.tb_blk_size || bus.tb_num_blocks == 4'd0)
                                        ? 4'd1 : bus.tb_num_blocks;
                        block_size_r <= bus.tb_blk_size;
                        crc_start_r  <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    crc_start_r <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= ST_ALIGN;
                end
                ST_ALIGN: begin
                    cnt_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b1;
                    crc_end_r   <= (blk_left_r == 4'd1);
                    state_r     <= ST_DATA;
                end
                ST_DATA: begin
                    if (cnt_r == data_last_s) begin
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_CRC;
                    end else begin
                        cnt_r <= cnt_r + CNT_W_P'(1);
                    end
                end
                ST_CRC: begin
                    if (cnt_r == CRC_LAST) begin
                        cnt_r <= '0;
                        if (blk_left_r > 4'd1) begin
                            blk_left_r <= blk_left_r - 4'd1;
                            in_ready_r <= 1'b1;
                            crc_end_r  <= (blk_left_r == 4'd2);
                            state_r    <= ST_DATA;
                        end else begin
                            out_valid_r <= 1'b0;
                            state_r     <= ST_WAIT_DONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W_P'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.il_done) begin
                        crc_end_r    <= 1'b0;
                        block_size_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= '0;
                    blk_left_r   <= 4'd0;
                    crc_start_r  <= 1'b0;
                    crc_end_r    <= 1'b0;
                    block_size_r <= 1'b0;
                    in_ready_r   <= 1'b0;
                    out_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underrun flag: a missing source bit is replaced by 0 and remembered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else if (state_r == ST_DATA && !bus.in_valid) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_bit    = out_bit_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.crc_start  = crc_start_r;
    assign bus.crc_end    = crc_end_r;
    assign bus.block_size = block_size_r;
    assign bus.busy       = busy_r;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_crc24_cb_attach.sv
// Directed bench for crc24_cb_attach with a long-division CRC-24B reference.
module tb_crc24_cb_attach;

    localparam int          SK   = 1056;
    localparam int          LK   = 6144;
    localparam logic [23:0] GPOLY = 24'h800063;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    bit pay   [0:18359];
    bit exp_b [0:18431];
    bit msg   [0:6143];
    bit work  [0:6167];

    crc24_cb_attach_if bus_if();

    crc24_cb_attach dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] outs();
        return {24'd0, bus_if.in_ready, bus_if.out_bit, bus_if.out_valid, bus_if.crc_start,
                bus_if.crc_end, bus_if.block_size, bus_if.busy, bus_if.err};
    endfunction

    // Remainder of msg(x)*x^24 divided by G(x)
    function automatic logic [23:0] crc_ref(input int n);
        logic [23:0] r;
        for (int i = 0; i < n; i++) work[i] = msg[i];
        for (int i = n; i < n + 24; i++) work[i] = 1'b0;
        for (int i = 0; i < n; i++)
            if (work[i])
                for (int j = 1; j <= 24; j++) work[i+j] = work[i+j] ^ GPOLY[24-j];
        for (int j = 0; j < 24; j++) r[23-j] = work[n+j];
        return r;
    endfunction

    task automatic start_tb(input logic size, input logic [3:0] nblk);
        @(posedge clk); #1;
        bus_if.tb_start = 1'b1; bus_if.tb_blk_size = size; bus_if.tb_num_blocks = nblk;
        @(negedge clk);
        chk("idle_crc_start", 32'(bus_if.crc_start), 32'd0);
        @(posedge clk); #1;
        bus_if.tb_start = 1'b0;
        @(negedge clk);
        chk("arm_crc_start", 32'(bus_if.crc_start), 32'd1);
        chk("arm_block_size", 32'(bus_if.block_size), 32'(size));
        chk("arm_busy_valid", {30'd0, bus_if.busy, bus_if.out_valid}, 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("align_ctrl", {29'd0, bus_if.crc_start, bus_if.out_valid, bus_if.in_ready}, 32'd0);
    endtask

    task automatic run_tb(input logic size, input logic [3:0] nblk, input int drop_at,
                          input bit early_done, input bit poke_start);
        int k, d, nb, b, p, idx;
        int nvalid, nbad, nend, nrdy, nbs, nstart, nbusy;
        logic [23:0] c;
        k  = size ? LK : SK;
        d  = k - 24;
        nb = (!size || nblk == 4'd0) ? 1 : int'(nblk);
        for (int bb = 0; bb < nb; bb++) begin
            for (int pp = 0; pp < d; pp++) begin
                msg[pp] = (bb * d + pp == drop_at) ? 1'b0 : pay[bb * d + pp];
                exp_b[bb * k + pp] = msg[pp];
            end
            c = crc_ref(d);
            for (int j = 0; j < 24; j++) exp_b[bb * k + d + j] = c[23-j];
        end
        start_tb(size, nblk);
        nvalid = 0; nbad = 0; nend = 0; nrdy = 0; nbs = 0;
        for (int cyc = 0; cyc < nb * k; cyc++) begin
            b = cyc / k; p = cyc % k; idx = b * d + p;
            @(posedge clk); #1;
            if (p < d) begin
                bus_if.in_valid = (idx != drop_at);
                bus_if.in_bit   = (idx == drop_at) ? 1'b1 : pay[idx];
            end else begin
                bus_if.in_valid = 1'b0;
                bus_if.in_bit   = 1'b1;
            end
            @(negedge clk);
            if (bus_if.out_valid) nvalid++;
            if (bus_if.out_bit !== exp_b[cyc]) nbad++;
            if (bus_if.crc_end !== (b == nb - 1)) nend++;
            if (bus_if.in_ready !== (p < d)) nrdy++;
            if (bus_if.block_size !== size) nbs++;
        end
        chk("valid_count", 32'(nvalid), 32'(nb * k));
        chk("bit_mismatches", 32'(nbad), 32'd0);
        chk("crc_end_mismatches", 32'(nend), 32'd0);
        chk("in_ready_mismatches", 32'(nrdy), 32'd0);
        chk("block_size_mismatches", 32'(nbs), 32'd0);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0; bus_if.in_bit = 1'b0;
        bus_if.il_done  = early_done; bus_if.tb_start = poke_start;
        @(negedge clk);
        chk("wait_entry", {29'd0, bus_if.out_valid, bus_if.in_ready, bus_if.busy}, 32'd1);
        chk("wait_crc_end", 32'(bus_if.crc_end), 32'd1);
        if (!early_done) begin
            nstart = 0; nbusy = 0;
            for (int w = 0; w < 4; w++) begin
                @(posedge clk); #1;
                bus_if.tb_start = 1'b0;
                @(negedge clk);
                if (bus_if.crc_start) nstart++;
                if (!bus_if.busy) nbusy++;
            end
            chk("wait_no_crc_start", 32'(nstart), 32'd0);
            chk("wait_busy_drop", 32'(nbusy), 32'd0);
            @(posedge clk); #1;
            bus_if.il_done = 1'b1; bus_if.tb_start = poke_start;
            @(negedge clk);
            chk("done_cycle_busy", 32'(bus_if.busy), 32'd1);
        end
        @(posedge clk); #1;
        bus_if.il_done = 1'b0; bus_if.tb_start = 1'b0;
        @(negedge clk);
        chk("idle_return", {28'd0, bus_if.busy, bus_if.crc_end, bus_if.block_size, bus_if.crc_start}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_no_restart", {30'd0, bus_if.busy, bus_if.crc_start}, 32'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset_n = 1'b0;
        bus_if.tb_start = 1'b0; bus_if.tb_blk_size = 1'b0; bus_if.tb_num_blocks = 4'd0;
        bus_if.in_bit = 1'b0; bus_if.in_valid = 1'b0; bus_if.il_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", outs(), 32'd0);

        // all-zero small block: CRC must be zero
        for (int i = 0; i < 18360; i++) pay[i] = 1'b0;
        run_tb(1'b0, 4'd1, -1, 1'b0, 1'b0);
        chk("err_clean_t1", 32'(bus_if.err), 32'd0);

        // single leading one, nblocks=5 collapses to 1, il_done high on entry
        pay[0] = 1'b1;
        run_tb(1'b0, 4'd5, -1, 1'b1, 1'b0);

        // three back-to-back large blocks, tb_start poked while waiting
        for (int i = 0; i < 18360; i++) pay[i] = (($urandom & 32'd1) != 32'd0);
        run_tb(1'b1, 4'd3, -1, 1'b0, 1'b1);
        chk("err_clean_t3", 32'(bus_if.err), 32'd0);

        // underrun at payload bit 500
        for (int i = 0; i < 18360; i++) pay[i] = (($urandom & 32'd1) != 32'd0);
        run_tb(1'b0, 4'd1, 500, 1'b0, 1'b0);
        chk("err_sticky", 32'(bus_if.err), 32'd1);

        // asynchronous reset in the middle of a large block
        start_tb(1'b1, 4'd1);
        for (int cyc = 0; cyc <= 3000; cyc++) begin
            @(posedge clk); #1;
            bus_if.in_valid = 1'b1; bus_if.in_bit = 1'b1;
            @(negedge clk);
        end
        chk("pre_reset_active", {29'd0, bus_if.out_valid, bus_if.out_bit, bus_if.err}, 32'd7);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs", outs(), 32'd0);
        @(posedge clk); #1;
        chk("held_reset_outputs", outs(), 32'd0);
        bus_if.in_valid = 1'b0; bus_if.in_bit = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 18360; i++) pay[i] = (($urandom & 32'd1) != 32'd0);
        run_tb(1'b0, 4'd1, -1, 1'b0, 1'b0);
        chk("err_after_reset", 32'(bus_if.err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/crc24_cb_attach.md
Name: crc24_cb_attach

Overview:
- Stage directly upstream of the interleaver control FSM in the channel-coder chain.
- Accepts a serial transport-block bit stream and splits it into code blocks of 1056 or 6144 bits.
- Each code block carries K-24 payload bits followed by 24 bits of CRC-24B, emitted MSB first.
- Drives the interleaver's CRC_start, CRC_END and block_size controls with the timing that FSM expects, then waits for its done before accepting the next transport block.

Parameters:
- SMALL_K, 1056, code-block length in bits when tb_blk_size=0.
- LARGE_K, 6144, code-block length in bits when tb_blk_size=1.
- CRC_W, 24, CRC width in bits.
- CRC_POLY, 24'h800063, gCRC24B: D^24+D^23+D^6+D^5+D+1.
- CNT_W, 13, width of the bit counter (must hold LARGE_K-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tb_start  in  1  one-cycle pulse; request a new transport block. Sampled only in IDLE.
- tb_blk_size  in  1  0 = SMALL_K blocks, 1 = LARGE_K blocks. Latched on tb_start.
- tb_num_blocks  in  4  number of code blocks in the transport block. Latched on tb_start.
- in_bit  in  1  payload bit from the source.
- in_valid  in  1  in_bit is valid this cycle.
- in_ready  out  1  stage consumes in_bit this cycle.
- il_done  in  1  interleaver done flag.
- out_bit  out  1  bit to the interleaver RAM write port.
- out_valid  out  1  out_bit is meaningful.
- crc_start  out  1  to interleaver CRC_start.
- crc_end  out  1  to interleaver CRC_END.
- block_size  out  1  to interleaver block_size.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky underrun flag.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset: asserting reset_n low at any time, including mid-block, forces IDLE. All outputs go to 0, err clears, counters and CRC register clear.
- States: IDLE, ARM, ALIGN, DATA, CRC, WAIT_DONE.
- IDLE:
  - tb_start=1 latches the size and block count, then moves to ARM.
  - tb_num_blocks=0 is treated as 1.
  - tb_blk_size=0 forces the block count to 1, because the interleaver has no multi-block small mode.
  - tb_start in any other state is ignored.
- ARM: crc_start=1 for exactly this one cycle. block_size drives the latched size from ARM until the return to IDLE. Moves to ALIGN.
- ALIGN:
  - One idle cycle that matches the interleaver's one-cycle pre-write state.
  - The first payload bit appears on out_bit exactly 2 cycles after the crc_start cycle.
  - Clears the counter and the CRC register (to 0). Moves to DATA.
- DATA (K-24 cycles):
  - in_ready=1 and out_valid=1.
  - If in_valid=1: out_bit=in_bit.
  - If in_valid=0: out_bit=0 and err is set. The output cadence never stalls, because the interleaver writes every cycle.
  - The CRC register updates on the emitted bit: fb = crc[23]^bit; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
  - At count K-25 the counter clears and the state moves to CRC.
- CRC (24 cycles):
  - in_ready=0, out_valid=1, out_bit=crc[23], register shifts left by 1.
  - On the last CRC cycle, if blocks remain: decrement the block count, clear the CRC register and go to DATA on the next cycle. Large blocks are back-to-back with no gap.
  - Otherwise go to WAIT_DONE.
- crc_end: high from the first DATA cycle of the last code block until the return to IDLE.
- WAIT_DONE: out_valid=0, in_ready=0. Returns to IDLE on the first cycle with il_done=1.
- Simultaneous events:
  - il_done already high on entry to WAIT_DONE means exit the next cycle.
  - tb_start in the same cycle as the return to IDLE is ignored; it is sampled only while in IDLE.
- Latency and throughput: 1 payload bit per cycle. The end-to-end block cost is 2 + n*K cycles plus the interleaver drain.

Decomposition:
- Shared package (chcoder_pkg):
  - SMALL_K, LARGE_K, CRC_W, CRC24B_POLY constants.
  - Enum for the states above.
- One sub-module: crc24_serial. Bit-serial LFSR with clear, enable and shift-out controls, and a 24-bit state output. Reusable by the receive-side checker.

Test Plan:
- Reset, then tb_start with size=0, nblocks=1, and a 1032-bit all-zero payload. Required:
  - crc_start is high for 1 cycle.
  - First out_valid occurs 2 cycles later.
  - 1056 contiguous valid bits, with the last 24 equal to 0.
  - crc_end is high throughout; block_size=0.
- Size=0 with payload 1 followed by 1031 zeros. Required: CRC bits equal to the software gCRC24B of that payload (golden model), MSB first.
- Size=1, nblocks=3, random payload. Required:
  - 3×6144 contiguous valid bits with no gap.
  - crc_end rises on the first data cycle of block 3.
  - busy stays high until il_done is pulsed.
- Drop in_valid for 1 cycle at bit 500. Required:
  - out_bit=0 on that cycle and err=1 until reset.
  - Total bit count unchanged.
- reset_n low at DATA bit 3000 of a large block. Required:
  - All outputs are 0 immediately (asynchronous).
  - After release, a new tb_start is accepted normally.
- tb_start pulsed while in WAIT_DONE. Required: ignored; no crc_start until after il_done and the return to IDLE.
